// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: shares the single DDR line port between the I-cache refill
// path (read-only) and the D-cache refill/writeback path (read/write).
// A grant is registered into the ram_* outputs and held until ddr_ctrl reports
// ready. The 256-bit line and a one-cycle ack then go back to the requester.
// A saturating watchdog raises a sticky flag if a transaction hangs.
module ddr_req_arbiter #(
    parameter bit                D_PRIORITY = 1'b0,
    parameter int unsigned       CNT_W      = 16,
    parameter logic [CNT_W-1:0]  TIMEOUT    = CNT_W'(16'hFFFF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [29:0]          i_addr,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_write,
    input  logic [29:0]          d_addr,
    input  logic [255:0]         d_wdata,
    output logic                 d_ack,
    output logic [255:0]         rdata,
    output logic                 ram_en,
    output logic                 ram_write,
    output logic [29:0]          ram_addr,
    output logic [255:0]         data_to_ram,
    input  logic                 ram_rdy,
    input  logic [255:0]         ram_rdata,
    output logic                 busy,
    output logic                 grant_d,
    output logic                 timeout_err
);

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned LINE_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic                last_grant_d, last_grant_d_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                pick_d;

    logic                i_ack_nxt;
    logic                d_ack_nxt;
    logic [LINE_W-1:0]   rdata_nxt;
    logic                ram_en_nxt;
    logic                ram_write_nxt;
    logic [ADDR_W-1:0]   ram_addr_nxt;
    logic [LINE_W-1:0]   data_to_ram_nxt;
    logic                busy_nxt;
    logic                grant_d_nxt;
    logic                timeout_err_nxt;

    // State, watchdog and registered outputs; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            last_grant_d <= 1'b0;
            cnt          <= '0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            rdata        <= '0;
            ram_en       <= 1'b0;
            ram_write    <= 1'b0;
            ram_addr     <= '0;
            data_to_ram  <= '0;
            busy         <= 1'b0;
            grant_d      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_grant_d <= last_grant_d_nxt;
            cnt          <= cnt_nxt;
            i_ack        <= i_ack_nxt;
            d_ack        <= d_ack_nxt;
            rdata        <= rdata_nxt;
            ram_en       <= ram_en_nxt;
            ram_write    <= ram_write_nxt;
            ram_addr     <= ram_addr_nxt;
            data_to_ram  <= data_to_ram_nxt;
            busy         <= busy_nxt;
            grant_d      <= grant_d_nxt;
            timeout_err  <= timeout_err_nxt;
        end
    end

    // Next-state and next-output logic; acks are prepared on the WAIT->DONE edge
    // so that the registered pulse lands in the DONE cycle.
    always_comb begin
        state_nxt        = state;
        last_grant_d_nxt = last_grant_d;
        cnt_nxt          = cnt;
        pick_d           = 1'b0;
        i_ack_nxt        = 1'b0;
        d_ack_nxt        = 1'b0;
        rdata_nxt        = rdata;
        ram_en_nxt       = ram_en;
        ram_write_nxt    = ram_write;
        ram_addr_nxt     = ram_addr;
        data_to_ram_nxt  = data_to_ram;
        grant_d_nxt      = grant_d;
        timeout_err_nxt  = timeout_err;

        case (state)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    if (i_req && d_req) begin
                        pick_d = D_PRIORITY ? 1'b1 : !last_grant_d;
                    end else begin
                        pick_d = d_req;
                    end
                    state_nxt   = ST_ISSUE;
                    ram_en_nxt  = 1'b1;
                    grant_d_nxt = pick_d;
                    if (pick_d) begin
                        ram_addr_nxt    = d_addr;
                        ram_write_nxt   = d_write;
                        data_to_ram_nxt = d_wdata;
                    end else begin
                        ram_addr_nxt  = i_addr;
                        ram_write_nxt = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                // ram_rdy may still be stale from the previous access here.
                state_nxt = ST_WAIT;
                cnt_nxt   = '0;
            end
            ST_WAIT: begin
                if (cnt != TIMEOUT) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt_nxt == TIMEOUT) begin
                        timeout_err_nxt = 1'b1;
                    end
                end
                if (ram_rdy) begin
                    state_nxt  = ST_DONE;
                    ram_en_nxt = 1'b0;
                    i_ack_nxt  = !grant_d;
                    d_ack_nxt  = grant_d;
                    if (!ram_write) begin
                        rdata_nxt = ram_rdata;
                    end
                end
            end
            ST_DONE: begin
                last_grant_d_nxt = grant_d;
                state_nxt        = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Bench for ddr_req_arbiter: directed scenarios plus randomized transactions,
// each checked against a transaction-level model of the arbitration rules.
module tb_ddr_req_arbiter;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned TMO    = 8;

    logic               clk;
    logic               rst;
    logic               i_req;
    logic [ADDR_W-1:0]  i_addr;
    logic               i_ack;
    logic               d_req;
    logic               d_write;
    logic [ADDR_W-1:0]  d_addr;
    logic [LINE_W-1:0]  d_wdata;
    logic               d_ack;
    logic [LINE_W-1:0]  rdata;
    logic               ram_en;
    logic               ram_write;
    logic [ADDR_W-1:0]  ram_addr;
    logic [LINE_W-1:0]  data_to_ram;
    logic               ram_rdy;
    logic [LINE_W-1:0]  ram_rdata;
    logic               busy;
    logic               grant_d;
    logic               timeout_err;

    // second instance: fixed D priority
    logic               fp_i_req;
    logic               fp_d_req;
    logic               fp_ram_rdy;
    logic               fp_i_ack;
    logic               fp_d_ack;
    logic [LINE_W-1:0]  fp_rdata;
    logic               fp_ram_en;
    logic               fp_ram_write;
    logic [ADDR_W-1:0]  fp_ram_addr;
    logic [LINE_W-1:0]  fp_data_to_ram;
    logic               fp_busy;
    logic               fp_grant_d;
    logic               fp_timeout_err;

    int n_chk;
    int n_err;

    // transaction-level model state
    bit                 m_last_d;
    logic [LINE_W-1:0]  m_rdata;
    logic [LINE_W-1:0]  m_dtr;

    ddr_req_arbiter #(.D_PRIORITY(1'b0), .CNT_W(16), .TIMEOUT(16'(TMO))) u_rr (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata),
        .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr), .data_to_ram(data_to_ram),
        .ram_rdy(ram_rdy), .ram_rdata(ram_rdata),
        .busy(busy), .grant_d(grant_d), .timeout_err(timeout_err)
    );

    ddr_req_arbiter #(.D_PRIORITY(1'b1)) u_fp (
        .clk(clk), .rst(rst),
        .i_req(fp_i_req), .i_addr(30'h0000_0040), .i_ack(fp_i_ack),
        .d_req(fp_d_req), .d_write(1'b0), .d_addr(30'h0000_0080), .d_wdata(256'h0), .d_ack(fp_d_ack),
        .rdata(fp_rdata),
        .ram_en(fp_ram_en), .ram_write(fp_ram_write), .ram_addr(fp_ram_addr), .data_to_ram(fp_data_to_ram),
        .ram_rdy(fp_ram_rdy), .ram_rdata(256'h5A),
        .busy(fp_busy), .grant_d(fp_grant_d), .timeout_err(fp_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic raise_i();
        i_req  = 1'b1;
        i_addr = ADDR_W'($urandom);
    endtask

    task automatic raise_d();
        d_req   = 1'b1;
        d_write = 1'($urandom);
        d_addr  = ADDR_W'($urandom);
        d_wdata = rand_line();
    endtask

    // One transaction starting in an IDLE cycle with at least one request up.
    // k = extra WAIT cycles before ready; stale = ram_rdy value during ISSUE.
    task automatic do_txn(input int k, input bit stale, input logic [LINE_W-1:0] line, input bit allow_raise);
        bit                win_d;
        logic [ADDR_W-1:0] ea;
        bit                ew;
        if (i_req && d_req) win_d = !m_last_d;
        else                win_d = d_req;
        ea = win_d ? d_addr : i_addr;
        ew = win_d ? d_write : 1'b0;
        if (win_d) m_dtr = d_wdata;

        tick();
        chk("issue_en", ram_en, 1);
        chk("issue_busy", busy, 1);
        chk("issue_grant", grant_d, win_d);
        chk("issue_addr", ram_addr, ea);
        chk("issue_write", ram_write, ew);
        chk("issue_dtr", data_to_ram, m_dtr);
        chk("issue_ack", {i_ack, d_ack}, 0);
        ram_rdy   = stale;
        ram_rdata = rand_line();
        if (win_d) begin
            d_addr  = ADDR_W'($urandom);
            d_wdata = rand_line();
        end else begin
            i_addr = ADDR_W'($urandom);
        end
        if (allow_raise) begin
            if (win_d && !i_req && ($urandom % 2 == 0)) raise_i();
            if (!win_d && !d_req && ($urandom % 2 == 0)) raise_d();
        end

        for (int j = 0; j <= k; j++) begin
            tick();
            chk("wait_en", ram_en, 1);
            chk("wait_addr", ram_addr, ea);
            chk("wait_write", ram_write, ew);
            chk("wait_dtr", data_to_ram, m_dtr);
            chk("wait_ack", {i_ack, d_ack}, 0);
            ram_rdy   = (j == k);
            ram_rdata = (j == k) ? line : rand_line();
        end

        tick();
        if (!ew) m_rdata = line;
        chk("done_iack", i_ack, !win_d);
        chk("done_dack", d_ack, win_d);
        chk("done_en", ram_en, 0);
        chk("done_rdata", rdata, m_rdata);
        chk("done_busy", busy, 1);
        chk("done_tmo", timeout_err, 0);
        if (win_d) d_req = 1'b0;
        else       i_req = 1'b0;
        m_last_d  = win_d;
        ram_rdy   = 1'($urandom);
        ram_rdata = rand_line();

        tick();
        chk("idle_busy", busy, 0);
        chk("idle_ack", {i_ack, d_ack}, 0);
        chk("idle_en", ram_en, 0);
        chk("idle_grant", grant_d, m_last_d);
        chk("idle_rdata", rdata, m_rdata);
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        m_last_d = 1'b0; m_rdata = '0; m_dtr = '0;
        rst = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        ram_rdy = 1'b0; ram_rdata = '0;
        fp_i_req = 1'b0; fp_d_req = 1'b0; fp_ram_rdy = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_en", ram_en, 0);
        chk("rst_write", ram_write, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_dtr", data_to_ram, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_acks", {i_ack, d_ack}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_d, 0);
        chk("rst_tmo", timeout_err, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);

        // ties from reset with ready stuck high: expect D, I, D, I
        raise_i(); raise_d();
        do_txn(0, 1'b1, rand_line(), 1'b0);
        chk("rr_first_is_d", m_last_d, 1);
        do_txn(0, 1'b1, rand_line(), 1'b0);
        tick();
        chk("gap_busy", busy, 0);
        raise_i(); raise_d();
        do_txn(0, 1'b1, rand_line(), 1'b0);
        do_txn(0, 1'b1, rand_line(), 1'b0);

        // single I read, ready 5 cycles after ram_en
        tick();
        i_req = 1'b1; i_addr = 30'h100;
        do_txn(4, 1'b0, {32{8'hA5}}, 1'b0);

        // D write leaves rdata untouched
        d_req = 1'b1; d_write = 1'b1; d_addr = 30'h2000; d_wdata = 256'h1234;
        do_txn(0, 1'b0, rand_line(), 1'b0);
        chk("wr_rdata_kept", rdata, {32{8'hA5}});

        // randomized traffic
        repeat (60) begin
            if (!i_req && m_last_d && ($urandom % 2 == 0)) raise_i();
            if (!d_req && !m_last_d && ($urandom % 2 == 0)) raise_d();
            if (!i_req && !d_req) begin
                tick();
                chk("rand_gap_busy", busy, 0);
                chk("rand_gap_en", ram_en, 0);
                case ($urandom % 3)
                    0:       raise_i();
                    1:       raise_d();
                    default: begin raise_i(); raise_d(); end
                endcase
            end
            do_txn(int'($urandom_range(5, 0)), 1'($urandom), rand_line(), 1'b1);
        end
        while (i_req || d_req) do_txn(0, 1'b0, rand_line(), 1'b0);

        // fixed priority: D held continuously starves I
        fp_ram_rdy = 1'b1; fp_i_req = 1'b1; fp_d_req = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            chk("fp_dack", fp_d_ack, (n % 4 == 3));
            chk("fp_iack", fp_i_ack, 0);
        end
        fp_d_req = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk("fp_iack_after", fp_i_ack, (n == 3));
            chk("fp_dack_after", fp_d_ack, 0);
        end
        fp_i_req = 1'b0;

        // watchdog, then asynchronous reset in the middle of WAIT
        tick();
        i_req = 1'b1; i_addr = 30'h3FF; ram_rdy = 1'b0;
        tick();
        chk("wd_issue_en", ram_en, 1);
        for (int j = 1; j <= 10; j++) begin
            tick();
            chk("wd_en", ram_en, 1);
            chk("wd_tmo", timeout_err, (j >= TMO + 1));
        end
        rst = 1'b0;
        #1;
        chk("arst_en", ram_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tmo", timeout_err, 0);
        i_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("post_arst_busy", busy, 0);
        chk("post_arst_tmo", timeout_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
